// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared types for the sequential shift-add multiplier:
//                control-FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // Width of the control-FSM state register
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_if
//  Description : Operand/product handshake bundle for seq_mult. The master
//                side presents operands and consumes products; the slave side
//                is the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, x, y, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, x, y, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface : seq_mult_if
`default_nettype wire

// File: rtl/seq_mult_cneg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_cneg
//  Description : Combinational conditional two's-complement negate. Used both
//                as an absolute-value stage (i_neg = sign bit) and as the
//                final sign-application stage of the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_cneg #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic             i_neg,
    output logic      [WIDTH-1:0] o_y
);

    // Negating the most-negative value wraps to the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    always_comb begin
        o_y = i_neg ? ((~i_a) + {{(WIDTH-1){1'b0}}, 1'b1}) : i_a;
    end

endmodule : seq_mult_cneg
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult
//  Description : Sequential shift-add multiplier, one partial product per
//                cycle, fixed WIDTH-cycle latency, signed/unsigned operands
//                and valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_mult_if.slave  bus
);

    // Control and datapath state
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH:0]     r_acc;      // {carry, upper half, multiplier}
    logic [WIDTH-1:0]     r_xmag;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_xmag;
    logic [WIDTH-1:0]     w_ymag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.p         = r_p;

    // Operand magnitudes; only negated when signed mode sees a set sign bit
    seq_mult_cneg #(.WIDTH(WIDTH)) u_abs_x (
        .i_a   (bus.x),
        .i_neg (bus.signed_mode & bus.x[WIDTH-1]),
        .o_y   (w_xmag)
    );

    seq_mult_cneg #(.WIDTH(WIDTH)) u_abs_y (
        .i_a   (bus.y),
        .i_neg (bus.signed_mode & bus.y[WIDTH-1]),
        .o_y   (w_ymag)
    );

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right by one.
    always_comb begin
        w_sum      = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_xmag})
                              : r_acc[2*WIDTH:WIDTH];
        w_acc_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};
    end

    // Apply the product sign to the magnitude left after the final step
    seq_mult_cneg #(.WIDTH(2*WIDTH)) u_neg_p (
        .i_a   (w_acc_next[2*WIDTH-1:0]),
        .i_neg (r_neg),
        .o_y   (w_prod)
    );

    // Control FSM with registered handshake outputs and product register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_xmag      <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_p         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_xmag     <= w_xmag;
                        r_acc      <= {{(WIDTH+1){1'b0}}, w_ymag};
                        r_neg      <= bus.signed_mode &
                                      (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_p         <= w_prod;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Return to IDLE only; a new request waits one cycle
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult
//  Description : Scoreboard bench for seq_mult (WIDTH=4) with directed
//                vectors and hand-computed products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [2*WIDTH-1:0] sb[$];

    seq_mult_if #(.WIDTH(WIDTH)) bus ();

    seq_mult #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, optionally record the product
    task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                         input logic sm, input logic push,
                         input logic [2*WIDTH-1:0] exp);
        int n;
        bus.x = xa;
        bus.y = ya;
        bus.signed_mode = sm;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 16'd1, 16'd0);
        if (push) sb.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid rises
    task automatic wait_out(input string name, input int latency);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check(name, 16'(cyc), 16'(latency));
    endtask

    // Full transaction with out_ready held high
    task automatic do_op(input string name, input logic [WIDTH-1:0] xa,
                         input logic [WIDTH-1:0] ya, input logic sm,
                         input logic [2*WIDTH-1:0] exp);
        issue(xa, ya, sm, 1'b1, exp);
        check({name, "_busy"}, 16'(bus.busy), 16'd1);
        wait_out({name, "_latency"}, 4);
        check({name, "_no_ready_in_done"}, 16'(bus.in_ready), 16'd0);
        tick();
        check({name, "_in_ready_after"}, 16'(bus.in_ready), 16'd1);
        check({name, "_out_valid_after"}, 16'(bus.out_valid), 16'd0);
    endtask

    // Monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_product", 16'(bus.p), 16'hFFFF);
            end else begin
                check("product", 16'(bus.p), 16'(sb.pop_front()));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_p", 16'(bus.p), 16'h0000);
        rst = 1'b0;
        tick();

        // Unsigned max and signed corner products
        do_op("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
        do_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
        do_op("s_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
        do_op("s_7xm8", 4'h7, 4'h8, 1'b1, 8'hC8);

        // Backpressure: hold out_ready low for 5 cycles
        bus.out_ready = 1'b0;
        issue(4'hD, 4'h5, 1'b1, 1'b1, 8'hF1);
        wait_out("bp_latency", 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 16'(bus.out_valid), 16'd1);
            check("bp_p_stable", 16'(bus.p), 16'h00F1);
            check("bp_in_ready", 16'(bus.in_ready), 16'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_released_valid", 16'(bus.out_valid), 16'd0);
        check("bp_released_ready", 16'(bus.in_ready), 16'd1);

        // Request during RUN is ignored
        issue(4'h3, 4'h4, 1'b0, 1'b1, 8'h0C);
        tick();
        bus.x = 4'h9;
        bus.y = 4'h9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("ign_latency", 2);
        tick();
        repeat (8) tick();
        check("ign_no_second", 16'(bus.busy), 16'd0);
        check("ign_p_held", 16'(bus.p), 16'h000C);

        // Reset during the second RUN cycle aborts the operation
        issue(4'hF, 4'hF, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("mid_rst_p", 16'(bus.p), 16'h0000);
        check("mid_rst_busy", 16'(bus.busy), 16'd0);
        do_op("u2x3", 4'h2, 4'h3, 1'b0, 8'h06);

        // Zero operand, then back-to-back request held high
        issue(4'h0, 4'hD, 1'b0, 1'b1, 8'h00);
        bus.x = 4'h1;
        bus.y = 4'h1;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        wait_out("zero_latency", 4);
        tick();
        check("b2b_idle_ready", 16'(bus.in_ready), 16'd1);
        check("b2b_idle_busy", 16'(bus.busy), 16'd0);
        sb.push_back(8'h01);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_accepted_busy", 16'(bus.busy), 16'd1);
        check("b2b_accepted_ready", 16'(bus.in_ready), 16'd0);
        wait_out("b2b_latency", 4);
        tick();

        repeat (4) tick();
        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_mult
`default_nettype wire

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-add multiplier. Successor to the team's combinational 4x4 multiplier core.
- Adds operand width as a parameter, signed/unsigned mode and valid/ready handshakes on input and output.
- Trades area for latency: one partial product per cycle.
- Sits behind the tt_um_ top-level wrapper. The wrapper maps operands from ui_in/uio_in and the product to uo_out.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), step-counter width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
x  input  WIDTH  multiplicand
y  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned
out_valid  output  1  product available
out_ready  input  1  consumer accepts product
p  output  2*WIDTH  product
busy  output  1  high in RUN state

Behaviour:
- Reset is sampled on clk only; it overrides everything, including mid-operation.
  - Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, p=0, counter=0.
  - Any in-flight operation is aborted; no product is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, capture operands and mode, clear the accumulator, set counter=0, go to RUN.
- Operand conditioning at capture:
  - Unsigned mode: magnitudes = x, y.
  - Signed mode: magnitudes = |x|, |y|, held as unsigned WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1) without error. neg = x[MSB]^y[MSB].
- RUN (in_ready=0, busy=1):
  - Each cycle: if the multiplier LSB = 1, add the multiplicand magnitude into the upper half of the 2*WIDTH+1-bit accumulator; then shift right 1; counter++.
  - Exactly WIDTH cycles; no zero-skipping, so latency is fixed.
- End of RUN:
  - On the edge where counter reaches WIDTH-1, the final step is performed.
  - p is loaded with the magnitude, or its two's-complement negation if neg=1.
  - State goes to DONE.
  - Result: out_valid rises exactly WIDTH cycles after the input-handshake edge.
- DONE:
  - out_valid=1; p is stable and must not change while out_valid=1 and out_ready=0 (backpressure of any length).
  - On out_valid&&out_ready: go to IDLE. out_valid=0 and in_ready=1 from the next cycle.
  - No new input is accepted in the same cycle as the output handshake. Throughput is one product per WIDTH+2 cycles minimum.
- p holds its last value after the output handshake until the next completion; it is not cleared.
- in_valid outside IDLE is ignored; operand changes during RUN/DONE have no effect.
- Product width rules:
  - Signed range: -2^(2W-2)+2^(W-1) .. 2^(2W-2); always fits 2*WIDTH signed bits.
  - Unsigned maximum: (2^W-1)^2; fits 2*WIDTH bits.
- A zero operand still takes WIDTH cycles.
- signed_mode is sampled only at capture.

Decomposition:
- Shared package seq_mult_pkg: state enum (IDLE, RUN, DONE) and the state encoding width localparam.
- One natural sub-module: seq_mult_cneg (combinational conditional negate/absolute value, parametrised width). Used at operand capture (abs) and at result load (negate).
- Accumulator, counter and FSM stay in seq_mult.

Test Plan (WIDTH=4):
- Unsigned x=15, y=15, out_ready=1 -> out_valid exactly 4 cycles after accept, p=0xE1 (225); in_ready back high the cycle after the output handshake.
- Signed x=-8 (0x8), y=-8 -> p=0x40 (+64). Signed x=-3 (0xD), y=5 -> p=0xF1 (-15). Signed x=7, y=-8 -> p=0xC8 (-56).
- Backpressure: signed -3*5 with out_ready=0 for 5 cycles -> out_valid stays 1, p stays 0xF1, in_ready stays 0; accepted on the first out_ready=1.
- Input ignored mid-op: accept 3*4 unsigned, then pulse in_valid with x=9, y=9 during RUN -> p=0x0C; the second request is not captured.
- Reset mid-RUN: accept 15*15, assert rst on the 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, p=0, busy=0. Then 2*3 -> p=0x06 after 4 cycles.
- Zero and back-to-back: 0*13 -> p=0x00 with 4-cycle latency. Immediately re-present 1*1 while in_valid is held high -> accepted the cycle after return to IDLE, p=0x01.
